mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-ported unified instruction/data memory between the pipeline's IF stage (instruction fetch port) and MEM stage (load/store port). It issues one access at a time to the memory array, counts down a fixed read latency, and returns read data to the owning requester. Data accesses have priority, with an optional starvation guard for fetch. It also drops fetch responses invalidated by a taken branch.

## Interface
Parameters:
- AW, 10, memory word-address width (1024-word array)
- DW, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (≥1)
- STARVE_MAX, 4, consecutive lost fetch arbitrations before fetch is forced to win (≥1)

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt, may be withdrawn before grant
- if_addr  in  AW  fetch word address
- if_flush  in  1  discard the outstanding fetch response (taken branch)
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rdata  out  DW  fetch read data, valid with if_rvalid
- if_rvalid  out  1  one-cycle fetch response pulse
- dm_req  in  1  data request; req/we/addr/wdata held stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  one-cycle grant pulse to data port
- dm_rdata  out  DW  load data, valid with dm_rvalid
- dm_rvalid  out  1  one-cycle load response pulse (never for stores)
- mem_en, mem_we  out  1  memory access strobe / write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests. None → stay. Otherwise pick winner, latch owner/addr/we/wdata, go ISSUE.
- Winner: dm if dm_req, else if. With guard enabled, if wins when if_req and starve_cnt == STARVE_MAX.
- ISSUE (1 cycle): winner's gnt=1, mem_en=1, mem_we/addr/wdata from latched values. Store → IDLE. Load/fetch → WAIT with lat_cnt=MEM_LAT.
- WAIT: lat_cnt decrements each cycle; at lat_cnt==1 capture mem_rdata into owner's rdata register, go RESP.
- RESP (1 cycle): owner's rvalid=1 unless owner=if and drop flag set; go IDLE.
- Drop flag: set by if_flush in any ISSUE/WAIT cycle of a fetch; cleared on leaving RESP. if_flush in IDLE or RESP has no effect.
- Only one access outstanding; non-owner requests wait.
- rdata registers hold last value between responses; unused port's rdata unchanged.

## Timing
- Reset: state=IDLE; all gnt, rvalid, mem_en, mem_we, busy =0; mem_addr, mem_wdata, if_rdata, dm_rdata =0; starve_cnt=0; drop flag=0. Mid-access reset aborts the access with no response.
- Request seen in IDLE at cycle t → gnt and mem_en at t+1.
- Store: IDLE again at t+2; next grant no earlier than t+3.
- Read: rvalid at t+2+MEM_LAT, which is also the first cycle back in IDLE (arbitration there → next grant at t+3+MEM_LAT).
- Requests arriving during a busy state are evaluated only in IDLE; simultaneous if_req and dm_req resolve per priority rule.
- Withdrawn if_req before grant: no access issued.

## Configuration
- ARB_STARVE_GUARD_EN defined: starve_cnt (saturating at STARVE_MAX) increments at each IDLE arbitration where if_req=1 and dm wins; clears when if wins or if_req=0 at arbitration; at STARVE_MAX fetch wins over dm.
- Undefined: strict dm priority, no counter; fetch may starve indefinitely.

## Test plan
- Reset, then if_req with if_addr=5 and MEM_LAT=1 → if_gnt at cycle 1, mem_en/mem_addr=5 at cycle 1, if_rvalid with if_rdata=Mem[5] at cycle 3.
- dm_req store addr=7 wdata=0xDEADBEEF → mem_we=1 at cycle 1, no dm_rvalid; later load addr=7 returns 0xDEADBEEF.
- if_req and dm_req held together (guard off) → dm granted every arbitration, if_gnt never; guard on, STARVE_MAX=4 → 5th arbitration grants if.
- Fetch granted, if_flush pulsed during WAIT → no if_rvalid; next fetch returns normally.
- rst asserted during WAIT of a load → all outputs 0 immediately, no dm_rvalid; following request serviced normally.
- MEM_LAT=3, back-to-back loads → dm_rvalid every 5 cycles, each data matching address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported I/D memory between fetch (if_*) and load/store (dm_*).
// Latency: grant + mem_en one cycle after a request is seen; read data MEM_LAT+1 cycles after grant.
// Backpressure: one access in flight; losing/late requesters simply hold req. Define ARB_STARVE_GUARD_EN for fetch anti-starvation.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int LW = $clog2(MEM_LAT + 1);

  logic [1:0]    state_q, state_d;
  logic          own_if_q, own_if_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          drop_q, drop_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic arb_slot;
  logic pick_if;
  logic pick_dm;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_q, starve_d;

  // Count consecutive arbitrations that fetch lost to data; saturate at the limit.
  always_comb begin
    starve_d = starve_q;
    if (arb_slot) begin
      if (!if_req || pick_if) begin
        starve_d = '0;
      end else if (pick_dm && (starve_q != CW'(STARVE_MAX))) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`endif

  // Winner selection. RESP doubles as an arbitration slot so consecutive
  // reads run at one access per MEM_LAT+2 cycles.
  always_comb begin
    arb_slot = (state_q == S_IDLE) || (state_q == S_RESP);
`ifdef ARB_STARVE_GUARD_EN
    pick_if  = if_req && (!dm_req || (starve_q == CW'(STARVE_MAX)));
`else
    pick_if  = if_req && !dm_req;
`endif
    pick_dm  = dm_req && !pick_if;
  end

  // Access sequencing: issue, count down read latency, capture data, respond.
  always_comb begin
    state_d    = state_q;
    own_if_d   = own_if_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    drop_d     = drop_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      S_ISSUE: begin
        if (own_if_q && if_flush) drop_d = 1'b1;
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          lat_d   = LW'(MEM_LAT);
        end
      end
      S_WAIT: begin
        if (own_if_q && if_flush) drop_d = 1'b1;
        if (lat_q == LW'(1)) begin
          if (own_if_q) if_rdata_d = mem_rdata;
          else          dm_rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_RESP: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: ;
    endcase
    if (arb_slot && (pick_if || pick_dm)) begin
      state_d  = S_ISSUE;
      own_if_d = pick_if;
      we_d     = pick_dm && dm_we;
      addr_d   = pick_if ? if_addr : dm_addr;
      if (pick_dm) wdata_d = dm_wdata;
    end
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      own_if_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      drop_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      own_if_q   <= own_if_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      drop_q     <= drop_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    if_gnt    = (state_q == S_ISSUE) && own_if_q;
    dm_gnt    = (state_q == S_ISSUE) && !own_if_q;
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rvalid = (state_q == S_RESP) && own_if_q && !drop_q;
    dm_rvalid = (state_q == S_RESP) && !own_if_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on a MEM_LAT=1 instance (a_*)
// and a MEM_LAT=3 instance (b_*), each with a small behavioural memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int a);
    return 32'hA5A50000 | 32'(a);
  endfunction

  // ---------------- instance A, MEM_LAT = 1 ----------------
  logic        a_if_req, a_if_flush, a_if_gnt, a_if_rvalid;
  logic [9:0]  a_if_addr;
  logic [31:0] a_if_rdata;
  logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
  logic [9:0]  a_dm_addr;
  logic [31:0] a_dm_wdata, a_dm_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_flush(a_if_flush),
    .if_gnt(a_if_gnt), .if_rdata(a_if_rdata), .if_rvalid(a_if_rvalid),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_gnt(a_dm_gnt), .dm_rdata(a_dm_rdata), .dm_rvalid(a_dm_rvalid),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  // Memory A: background pattern plus one remembered store.
  logic        st_vld;
  logic [9:0]  st_addr;
  logic [31:0] st_val;
  logic [31:0] a_rd;
  always @(posedge clk) begin
    if (rst) st_vld <= 1'b0;
    else if (a_mem_en && a_mem_we) begin
      st_vld  <= 1'b1;
      st_addr <= a_mem_addr;
      st_val  <= a_mem_wdata;
    end
    if (a_mem_en && !a_mem_we)
      a_rd <= (st_vld && st_addr == a_mem_addr) ? st_val : pat(int'(a_mem_addr));
  end
  assign a_mem_rdata = a_rd;

  // ---------------- instance B, MEM_LAT = 3 ----------------
  logic        b_if_req, b_if_flush, b_if_gnt, b_if_rvalid;
  logic [9:0]  b_if_addr;
  logic [31:0] b_if_rdata;
  logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
  logic [9:0]  b_dm_addr;
  logic [31:0] b_dm_wdata, b_dm_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_flush(b_if_flush),
    .if_gnt(b_if_gnt), .if_rdata(b_if_rdata), .if_rvalid(b_if_rvalid),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rdata(b_dm_rdata), .dm_rvalid(b_dm_rvalid),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory B: three-stage read pipeline, pattern contents.
  logic [31:0] b_p0, b_p1, b_p2;
  always @(posedge clk) begin
    b_p1 <= b_p0;
    b_p2 <= b_p1;
    if (b_mem_en && !b_mem_we) b_p0 <= pat(int'(b_mem_addr));
  end
  assign b_mem_rdata = b_p2;

  // One cycle = one negedge; inputs set at a negedge are sampled at the next posedge.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_mem_en, a_mem_we, a_busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_mem_en, a_mem_we, a_busy});
    end
    checks++;
    if ({a_mem_addr, a_mem_wdata} !== 42'h0) begin
      failures++; $display("FAIL reset_mem_bus addr=%h wdata=%h exp=0", a_mem_addr, a_mem_wdata);
    end
    checks++;
    if ({a_if_rdata, a_dm_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata if=%h dm=%h exp=0", a_if_rdata, a_dm_rdata);
    end
    checks++;
    if (b_busy !== 1'b0) begin
      failures++; $display("FAIL reset_b_busy got=%b exp=0", b_busy);
    end
  endtask

  task automatic test_fetch();
    a_if_req = 1'b1; a_if_addr = 10'd5;
    checks++;
    if (a_if_gnt !== 1'b0) begin failures++; $display("FAIL fetch_c0_gnt got=%b exp=0", a_if_gnt); end
    next_cyc();  // cycle 1
    checks++;
    if ({a_if_gnt, a_mem_en, a_mem_we, a_busy} !== 4'b1101 || a_mem_addr !== 10'd5) begin
      failures++;
      $display("FAIL fetch_c1_issue gnt/en/we/busy=%b addr=%0d exp=1101 addr=5",
               {a_if_gnt, a_mem_en, a_mem_we, a_busy}, a_mem_addr);
    end
    a_if_req = 1'b0;
    next_cyc();  // cycle 2
    checks++;
    if (a_if_rvalid !== 1'b0 || a_mem_en !== 1'b0) begin
      failures++; $display("FAIL fetch_c2_wait rvalid=%b en=%b exp=0 0", a_if_rvalid, a_mem_en);
    end
    next_cyc();  // cycle 3
    checks++;
    if (a_if_rvalid !== 1'b1 || a_if_rdata !== pat(5) || a_dm_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c3_resp rvalid=%b data=%h dm_rvalid=%b exp=1 %h 0",
               a_if_rvalid, a_if_rdata, a_dm_rvalid, pat(5));
    end
    next_cyc();  // cycle 4
    checks++;
    if (a_if_rvalid !== 1'b0 || a_busy !== 1'b0 || a_if_rdata !== pat(5)) begin
      failures++;
      $display("FAIL fetch_c4_idle rvalid=%b busy=%b data=%h exp=0 0 %h",
               a_if_rvalid, a_busy, a_if_rdata, pat(5));
    end
    next_cyc();
  endtask

  task automatic test_store_then_load();
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 10'd7; a_dm_wdata = 32'hDEADBEEF;
    next_cyc();  // cycle 1
    checks++;
    if ({a_dm_gnt, a_mem_en, a_mem_we} !== 3'b111 || a_mem_addr !== 10'd7 || a_mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_issue gnt/en/we=%b addr=%0d wdata=%h exp=111 7 deadbeef",
               {a_dm_gnt, a_mem_en, a_mem_we}, a_mem_addr, a_mem_wdata);
    end
    a_dm_we = 1'b0;  // follow with a load of the same word, request kept high
    next_cyc();  // cycle 2
    checks++;
    if (a_dm_gnt !== 1'b0 || a_busy !== 1'b0 || a_dm_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL store_c2_idle gnt=%b busy=%b rvalid=%b exp=0 0 0", a_dm_gnt, a_busy, a_dm_rvalid);
    end
    next_cyc();  // cycle 3
    checks++;
    if (a_dm_gnt !== 1'b1 || a_mem_we !== 1'b0) begin
      failures++; $display("FAIL load_c3_gnt gnt=%b we=%b exp=1 0", a_dm_gnt, a_mem_we);
    end
    a_dm_req = 1'b0;
    next_cyc();  // cycle 4
    checks++;
    if (a_dm_rvalid !== 1'b0) begin failures++; $display("FAIL load_c4_rvalid got=%b exp=0", a_dm_rvalid); end
    next_cyc();  // cycle 5
    checks++;
    if (a_dm_rvalid !== 1'b1 || a_dm_rdata !== 32'hDEADBEEF || a_if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL load_c5_resp rvalid=%b data=%h if_rvalid=%b exp=1 deadbeef 0",
               a_dm_rvalid, a_dm_rdata, a_if_rvalid);
    end
    checks++;
    if (a_if_rdata !== pat(5)) begin
      failures++; $display("FAIL if_rdata_held got=%h exp=%h", a_if_rdata, pat(5));
    end
    next_cyc();
    next_cyc();
  endtask

  task automatic test_priority();
    int n_if, n_dm, ngrant, first_if, exp_if, exp_first;
    n_if = 0; n_dm = 0; ngrant = 0; first_if = 0;
    a_if_req = 1'b1; a_if_addr = 10'd9; a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 10'd3;
    for (int c = 1; c <= 20; c++) begin
      next_cyc();
      if (a_if_gnt) begin ngrant++; n_if++; if (first_if == 0) first_if = ngrant; end
      if (a_dm_gnt) begin ngrant++; n_dm++; end
    end
    a_if_req = 1'b0; a_dm_req = 1'b0;
    repeat (3) next_cyc();
`ifdef ARB_STARVE_GUARD_EN
    exp_if = 1; exp_first = 5;
`else
    exp_if = 0; exp_first = 0;
`endif
    checks++;
    if (ngrant !== 7) begin failures++; $display("FAIL prio_grant_total got=%0d exp=7", ngrant); end
    checks++;
    if (n_if !== exp_if || n_dm !== 7 - exp_if) begin
      failures++; $display("FAIL prio_split if=%0d dm=%0d exp=%0d %0d", n_if, n_dm, exp_if, 7 - exp_if);
    end
    checks++;
    if (first_if !== exp_first) begin
      failures++; $display("FAIL prio_first_if got=%0d exp=%0d", first_if, exp_first);
    end
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL prio_drain busy=%b exp=0", a_busy); end
  endtask

  task automatic test_flush();
    int seen;
    // Flush while idle must not affect the fetch that is granted next.
    a_if_req = 1'b1; a_if_addr = 10'd11; a_if_flush = 1'b1;
    next_cyc();  // cycle 1 (ISSUE)
    a_if_flush = 1'b0; a_if_req = 1'b0;
    next_cyc(); next_cyc();  // cycle 3 (RESP)
    checks++;
    if (a_if_rvalid !== 1'b1 || a_if_rdata !== pat(11)) begin
      failures++; $display("FAIL flush_idle_noeffect rvalid=%b data=%h exp=1 %h", a_if_rvalid, a_if_rdata, pat(11));
    end
    next_cyc();
    // Flush during WAIT suppresses the response.
    a_if_req = 1'b1; a_if_addr = 10'd12;
    next_cyc();  // cycle 1
    a_if_req = 1'b0;
    next_cyc();  // cycle 2 (WAIT)
    a_if_flush = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      a_if_flush = 1'b0;
      if (a_if_rvalid) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_drop rvalid_pulses=%0d exp=0", seen); end
    // Next fetch returns normally.
    a_if_req = 1'b1; a_if_addr = 10'd13;
    next_cyc();
    a_if_req = 1'b0;
    next_cyc(); next_cyc();
    checks++;
    if (a_if_rvalid !== 1'b1 || a_if_rdata !== pat(13)) begin
      failures++; $display("FAIL flush_after rvalid=%b data=%h exp=1 %h", a_if_rvalid, a_if_rdata, pat(13));
    end
    next_cyc();
  endtask

  task automatic test_reset_mid();
    int seen;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 10'd20;
    next_cyc();  // cycle 1
    a_dm_req = 1'b0;
    next_cyc();  // cycle 2 (WAIT)
    rst = 1'b1;
    #1;
    checks++;
    if ({a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_mem_en, a_mem_we, a_busy} !== 7'b0 ||
        a_mem_addr !== 10'd0 || a_dm_rdata !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs ctrl=%b addr=%0d dm_rdata=%h exp=0",
               {a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_mem_en, a_mem_we, a_busy},
               a_mem_addr, a_dm_rdata);
    end
    next_cyc();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      if (a_dm_rvalid || a_busy) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midreset_no_resp activity=%0d exp=0", seen); end
    a_dm_req = 1'b1; a_dm_addr = 10'd21;
    next_cyc();
    a_dm_req = 1'b0;
    next_cyc(); next_cyc();
    checks++;
    if (a_dm_rvalid !== 1'b1 || a_dm_rdata !== pat(21)) begin
      failures++; $display("FAIL midreset_after rvalid=%b data=%h exp=1 %h", a_dm_rvalid, a_dm_rdata, pat(21));
    end
    next_cyc();
  endtask

  task automatic test_back_to_back();
    int ngnt, nresp;
    ngnt = 0; nresp = 0;
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 10'd100;
    for (int c = 1; c <= 25; c++) begin
      next_cyc();
      if (b_dm_rvalid) begin
        checks++;
        if (c !== 5 * (nresp + 1) || b_dm_rdata !== pat(100 + nresp)) begin
          failures++;
          $display("FAIL b2b_resp%0d cycle=%0d data=%h exp cycle=%0d data=%h",
                   nresp, c, b_dm_rdata, 5 * (nresp + 1), pat(100 + nresp));
        end
        nresp++;
      end
      if (b_dm_gnt) begin
        ngnt++;
        if (ngnt < 3) b_dm_addr = 10'(100 + ngnt);
        else          b_dm_req  = 1'b0;
      end
    end
    checks++;
    if (nresp !== 3 || ngnt !== 3) begin
      failures++; $display("FAIL b2b_count resp=%0d gnt=%0d exp=3 3", nresp, ngnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_if_req = 1'b0; a_if_addr = '0; a_if_flush = 1'b0;
    a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_addr = '0; a_dm_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_if_flush = 1'b0;
    b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
    next_cyc();
    next_cyc();
    test_reset();
    rst = 1'b0;
    next_cyc();
    test_fetch();
    test_store_then_load();
    test_priority();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
